// File: rtl/digilock_pkg.sv
// Shared types and constants for the DigiLock code controller slice.
package digilock_pkg;

  localparam int CODE_LEN = 4;
  localparam int DIGIT_W  = 4;
  localparam int IDX_W    = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTER   = 3'd1,
    CMP     = 3'd2,
    OPEN    = 3'd3,
    PROG    = 3'd4,
    WRITE   = 3'd5,
    LOCKOUT = 3'd6
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/digilock_down_timer.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module digilock_down_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/digilock_code_ctrl.sv
// DigiLock code entry/compare/programming controller for the 4x4-bit code memory.
// Optional consecutive-failure lockout is built when DIGILOCK_LOCKOUT_EN is defined.
module digilock_code_ctrl
  import digilock_pkg::*;
#(
  parameter int OPEN_CYCLES    = 8,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  output logic               digit_ready,
  input  logic               clear,
  input  logic               prog_req,
  output logic [IDX_W-1:0]   mem_idx,
  output logic               mem_wr,
  output logic               mem_enable,
  output logic [DIGIT_W-1:0] mem_wdata,
  input  logic [DIGIT_W-1:0] mem_rdata,
  output logic               unlocked,
  output logic               error,
  output logic               locked_out
);

  localparam int TW = $clog2(max2(OPEN_CYCLES, LOCKOUT_CYCLES) + 1);
  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(CODE_LEN - 1);

  if (OPEN_CYCLES < 1 || MAX_FAILS < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_cfg
    $error("digilock_code_ctrl: OPEN_CYCLES, MAX_FAILS and LOCKOUT_CYCLES must be >= 1");
  end

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   pos;
  logic [DIGIT_W-1:0] digit_q;
  logic               mismatch;
  logic               err_q;
  logic               accept;
  logic               mismatch_all;
  logic               last_cmp;
  logic               lockout_hit;
  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               tmr_dec;
  logic               tmr_zero;

  // A clear during entry beats a simultaneous digit.
  assign accept       = digit_valid && digit_ready && !((state == ENTER) && clear);
  assign mismatch_all = mismatch || (mem_rdata != digit_q);
  assign last_cmp     = (state == CMP) && (pos == LAST_POS);

`ifdef DIGILOCK_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAILS + 1);
  logic [FW-1:0] fail_cnt;
  logic [FW-1:0] fail_inc;

  assign fail_inc    = (fail_cnt == FW'(MAX_FAILS)) ? fail_cnt : fail_cnt + 1'b1;
  assign lockout_hit = (fail_inc == FW'(MAX_FAILS));

  always_ff @(posedge clk) begin
    if (!reset) begin
      fail_cnt <= '0;
    end else if (last_cmp) begin
      fail_cnt <= mismatch_all ? fail_inc : '0;
    end else if ((state == LOCKOUT) && tmr_zero) begin
      fail_cnt <= '0;
    end
  end
`else
  assign lockout_hit = 1'b0;
`endif

  digilock_down_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // State and control registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      pos      <= '0;
      mismatch <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= last_cmp && mismatch_all;
      case (state)
        ENTER: begin
          if (clear) begin
            pos      <= '0;
            mismatch <= 1'b0;
          end
        end
        CMP: begin
          pos      <= pos + 1'b1;
          mismatch <= (pos == LAST_POS) ? 1'b0 : mismatch_all;
        end
        OPEN: begin
          if (prog_req) pos <= '0;
        end
        WRITE: pos <= pos + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) digit_q <= digit;
  end

  // Next-state and timer control
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = CMP;
      ENTER: begin
        if (clear)       state_nxt = IDLE;
        else if (accept) state_nxt = CMP;
      end
      CMP: begin
        if (pos != LAST_POS) begin
          state_nxt = ENTER;
        end else if (!mismatch_all) begin
          state_nxt = OPEN;
          tmr_load  = 1'b1;
          tmr_val   = TW'(OPEN_CYCLES - 1);
        end else if (lockout_hit) begin
          state_nxt = LOCKOUT;
          tmr_load  = 1'b1;
          tmr_val   = TW'(LOCKOUT_CYCLES - 1);
        end else begin
          state_nxt = IDLE;
        end
      end
      OPEN: begin
        tmr_dec = 1'b1;
        if (prog_req)      state_nxt = PROG;
        else if (tmr_zero) state_nxt = IDLE;
      end
      PROG:  if (accept) state_nxt = WRITE;
      WRITE: state_nxt = (pos == LAST_POS) ? IDLE : PROG;
`ifdef DIGILOCK_LOCKOUT_EN
      LOCKOUT: begin
        tmr_dec = 1'b1;
        if (tmr_zero) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    digit_ready = (state == IDLE) || (state == ENTER) || (state == PROG);
    mem_enable  = (state == CMP) || (state == WRITE);
    mem_wr      = (state == WRITE);
    mem_idx     = mem_enable ? pos : '0;
    mem_wdata   = (state == WRITE) ? digit_q : '0;
    unlocked    = (state == OPEN) || (state == PROG) || (state == WRITE);
    error       = err_q;
`ifdef DIGILOCK_LOCKOUT_EN
    locked_out  = (state == LOCKOUT);
`else
    locked_out  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_digilock_code_ctrl.sv
// Directed, table-driven bench for digilock_code_ctrl with a behavioural code memory.
module tb_digilock_code_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       digit_valid;
  logic [3:0] digit;
  logic       digit_ready;
  logic       clear;
  logic       prog_req;
  logic [1:0] mem_idx;
  logic       mem_wr;
  logic       mem_enable;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;
  logic       unlocked;
  logic       error;
  logic       locked_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  digilock_code_ctrl #(.OPEN_CYCLES(8), .MAX_FAILS(3), .LOCKOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .digit_valid (digit_valid),
    .digit       (digit),
    .digit_ready (digit_ready),
    .clear       (clear),
    .prog_req    (prog_req),
    .mem_idx     (mem_idx),
    .mem_wr      (mem_wr),
    .mem_enable  (mem_enable),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .unlocked    (unlocked),
    .error       (error),
    .locked_out  (locked_out)
  );

  // Code memory: clears on reset, combinational read
  logic [3:0] mem [4];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) mem[i] <= 4'h0;
    end else if (mem_enable && mem_wr) begin
      mem[mem_idx] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_enable && !mem_wr) ? mem[mem_idx] : 4'h0;

  typedef struct {
    logic       dv;
    logic [3:0] d;
    logic       clr;
    logic       pr;
    logic [11:0] exp;
  } vec_t;

  vec_t vq[$];

  wire [11:0] obs = {digit_ready, unlocked, error, locked_out, mem_enable, mem_wr, mem_idx, mem_wdata};

  function automatic logic [11:0] ex(input logic rdy, input logic unl, input logic err,
                                     input logic en, input logic wr, input logic [1:0] idx,
                                     input logic [3:0] wd);
    return {rdy, unl, err, 1'b0, en, wr, idx, wd};
  endfunction

  task automatic push(input logic dv, input logic [3:0] d, input logic pr, input logic [11:0] e);
    vec_t v;
    v.dv = dv; v.d = d; v.clr = 1'b0; v.pr = pr; v.exp = e;
    vq.push_back(v);
  endtask

  // Digit accepted in IDLE/ENTER, then the CMP read cycle
  task automatic r_digit(input logic [3:0] d, input logic [1:0] idx);
    push(1'b1, d, 1'b0, ex(1, 0, 0, 0, 0, 2'd0, 4'h0));
    push(1'b0, 4'h0, 1'b0, ex(0, 0, 0, 1, 0, idx, 4'h0));
  endtask

  task automatic r_open(input int n, input logic dv, input logic pr);
    for (int i = 0; i < n; i++) push(dv, 4'h7, pr, ex(0, 1, 0, 0, 0, 2'd0, 4'h0));
  endtask

  task automatic r_prog(input logic [3:0] d, input logic [1:0] idx);
    push(1'b1, d, 1'b0, ex(1, 1, 0, 0, 0, 2'd0, 4'h0));
    push(1'b0, 4'h0, 1'b0, ex(0, 1, 0, 1, 1, idx, d));
  endtask

  task automatic r_idle();
    push(1'b0, 4'h0, 1'b0, ex(1, 0, 0, 0, 0, 2'd0, 4'h0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic enter_digit(input logic [3:0] d, input logic [1:0] idx);
    digit_valid = 1'b1;
    digit = d;
    step();
    digit_valid = 1'b0;
    check($sformatf("cmp_read_idx%0d", idx), {28'd0, mem_enable, mem_wr, mem_idx}, {28'd0, 1'b1, 1'b0, idx});
    step();
  endtask

  task automatic enter_code(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input logic [3:0] e);
    enter_digit(a, 2'd0);
    enter_digit(b, 2'd1);
    enter_digit(c, 2'd2);
    enter_digit(e, 2'd3);
  endtask

  task automatic prog_digit(input logic [3:0] d, input logic [1:0] idx);
    digit_valid = 1'b1;
    digit = d;
    step();
    digit_valid = 1'b0;
    check($sformatf("write_idx%0d", idx), {20'd0, obs}, {20'd0, ex(0, 1, 0, 1, 1, idx, d)});
    step();
  endtask

  task automatic wait_relock();
    int k = 0;
    while (unlocked && k < 20) begin
      step();
      k++;
    end
    check("relock_within_bound", {31'd0, unlocked}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    digit_valid = 1'b0;
    digit = 4'h0;
    clear = 1'b0;
    prog_req = 1'b0;

    // Default code 0000 opens for 8 cycles, then relocks
    r_digit(4'h0, 2'd0); r_digit(4'h0, 2'd1); r_digit(4'h0, 2'd2); r_digit(4'h0, 2'd3);
    r_open(8, 1'b0, 1'b0);
    r_idle();
    // Reopen and program 1234
    r_digit(4'h0, 2'd0); r_digit(4'h0, 2'd1); r_digit(4'h0, 2'd2); r_digit(4'h0, 2'd3);
    r_open(1, 1'b0, 1'b1);
    r_prog(4'h1, 2'd0); r_prog(4'h2, 2'd1); r_prog(4'h3, 2'd2); r_prog(4'h4, 2'd3);
    r_idle();
    // New code opens; digits offered while open are dropped
    r_digit(4'h1, 2'd0); r_digit(4'h2, 2'd1); r_digit(4'h3, 2'd2); r_digit(4'h4, 2'd3);
    r_open(8, 1'b1, 1'b0);
    r_idle();

    step();
    step();
    check("reset_outputs", {20'd0, obs}, {20'd0, ex(1, 0, 0, 0, 0, 2'd0, 4'h0)});
    reset = 1'b1;

    foreach (vq[i]) begin
      digit_valid = vq[i].dv;
      digit       = vq[i].d;
      clear       = vq[i].clr;
      prog_req    = vq[i].pr;
      #1;
      check($sformatf("vec%0d", i), {20'd0, obs}, {20'd0, vq[i].exp});
      step();
    end
    digit_valid = 1'b0;
    prog_req = 1'b0;

    // Wrong code against stored 1234
    enter_code(4'h1, 4'h2, 4'h3, 4'h5);
    check("wrong_error_pulse", {30'd0, error, unlocked}, {30'd0, 1'b1, 1'b0});
    step();
    check("wrong_error_one_cycle", {20'd0, obs}, {20'd0, ex(1, 0, 0, 0, 0, 2'd0, 4'h0)});

    // Entry restarts at idx 0; clear with a simultaneous digit aborts
    enter_digit(4'h1, 2'd0);
    enter_digit(4'h2, 2'd1);
    clear = 1'b1;
    digit_valid = 1'b1;
    digit = 4'h3;
    step();
    clear = 1'b0;
    digit_valid = 1'b0;
    check("clear_wins_idle", {20'd0, obs}, {20'd0, ex(1, 0, 0, 0, 0, 2'd0, 4'h0)});
    step();
    check("clear_no_error", {31'd0, error}, 32'd0);
    enter_code(4'h1, 4'h2, 4'h3, 4'h4);
    check("after_clear_opens", {30'd0, unlocked, error}, {30'd0, 1'b1, 1'b0});

    // prog_req on the final open cycle beats timer expiry
    for (int i = 0; i < 7; i++) step();
    check("open_last_cycle", {31'd0, unlocked}, 32'd1);
    prog_req = 1'b1;
    step();
    prog_req = 1'b0;
    check("prog_priority", {20'd0, obs}, {20'd0, ex(1, 1, 0, 0, 0, 2'd0, 4'h0)});

    // Reset after two writes loses the partial code
    prog_digit(4'h5, 2'd0);
    prog_digit(4'h6, 2'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midprog_reset_outputs", {20'd0, obs}, {20'd0, ex(1, 0, 0, 0, 0, 2'd0, 4'h0)});
    enter_code(4'h1, 4'h2, 4'h0, 4'h0);
    check("code_1200_rejected", {30'd0, error, unlocked}, {30'd0, 1'b1, 1'b0});
    step();
    enter_code(4'h0, 4'h0, 4'h0, 4'h0);
    check("code_0000_after_reset", {31'd0, unlocked}, 32'd1);
    wait_relock();

`ifdef DIGILOCK_LOCKOUT_EN
    for (int f = 0; f < 3; f++) begin
      enter_code(4'h1, 4'h1, 4'h1, 4'h1);
      if (f < 2) begin
        check($sformatf("fail%0d_no_lockout", f), {30'd0, error, locked_out}, {30'd0, 1'b1, 1'b0});
        step();
      end
    end
    check("lockout_entry", {29'd0, error, locked_out, digit_ready}, {29'd0, 1'b1, 1'b1, 1'b0});
    for (int i = 0; i < 16; i++) begin
      check($sformatf("lockout_cyc%0d", i), {30'd0, locked_out, digit_ready}, {30'd0, 1'b1, 1'b0});
      digit_valid = 1'b1;
      digit = 4'h9;
      step();
    end
    digit_valid = 1'b0;
    check("lockout_exit", {20'd0, obs}, {20'd0, ex(1, 0, 0, 0, 0, 2'd0, 4'h0)});
    enter_code(4'h0, 4'h0, 4'h0, 4'h0);
    check("open_after_lockout", {31'd0, unlocked}, 32'd1);
`else
    for (int f = 0; f < 3; f++) begin
      enter_code(4'h1, 4'h1, 4'h1, 4'h1);
      check($sformatf("fail%0d_never_locks", f), {29'd0, error, locked_out, unlocked}, {29'd0, 1'b1, 1'b0, 1'b0});
      step();
    end
    enter_code(4'h0, 4'h0, 4'h0, 4'h0);
    check("open_after_retries", {31'd0, unlocked}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/digilock_code_ctrl.md
Name: digilock_code_ctrl

Overview:
- Initiator for the 4x4-bit code memory: accepts keypad digits, reads the stored 4-digit code and compares it against the entered digits.
- Drives the lock open/closed, and writes a new code when programming is requested while the lock is open.
- Sits between the keypad debouncer and the code memory in the DigiLock top level.

Parameters:
OPEN_CYCLES, 8, cycles unlocked stays high before auto-relock (>=1)
MAX_FAILS, 3, consecutive wrong codes before lockout (>=1; LOCKOUT_EN only)
LOCKOUT_CYCLES, 16, lockout duration in cycles (>=1; LOCKOUT_EN only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
digit_valid  in  1  keypad digit strobe
digit  in  4  digit value; any 4-bit value is legal
digit_ready  out  1  digit accepted this cycle when digit_valid&digit_ready
clear  in  1  abort current code entry
prog_req  in  1  request reprogramming; honoured only in OPEN
mem_idx  out  2  memory index
mem_wr  out  1  memory write select
mem_enable  out  1  memory enable
mem_wdata  out  4  memory write data
mem_rdata  in  4  memory read data; combinational, valid when enable&~wr
unlocked  out  1  lock open
error  out  1  one-cycle pulse on a wrong code
locked_out  out  1  lockout active (constant 0 without LOCKOUT_EN)

Behaviour:
- States: IDLE, ENTER, CMP, OPEN, PROG, WRITE, LOCKOUT. Registers: pos[1:0], digit_q[3:0], mismatch, timer, fail_cnt.
- Reset (reset==0 at posedge): state=IDLE, pos=0, mismatch=0, fail_cnt=0, timer=0. All outputs 0 except digit_ready=1. The memory clears to code 0000 on the same reset.
- digit_ready=1 in IDLE, ENTER and PROG; otherwise 0. Digits presented while digit_ready=0 are dropped.
- Memory outputs are Moore-decoded from state/pos/digit_q:
  - CMP: enable=1, wr=0, idx=pos.
  - WRITE: enable=1, wr=1, idx=pos, wdata=digit_q.
  - All other states: all mem outputs 0.
- IDLE/ENTER, digit accepted: digit_q<=digit, go to CMP.
- CMP, one cycle:
  - mismatch<=mismatch | (mem_rdata!=digit_q); pos<=pos+1 (2-bit, wraps to 0).
  - If pos!=3: go to ENTER.
  - If pos==3, verdict uses the combined mismatch. Match: OPEN, timer=OPEN_CYCLES-1, fail_cnt=0. Mismatch: error=1 for one cycle, fail_cnt+1, go to IDLE (or LOCKOUT).
  - mismatch clears on leaving CMP at pos==3.
- Latency: 4th digit accepted at cycle t -> unlocked or error is high in cycle t+2. Per-digit throughput is one digit per 2 cycles.
- clear in ENTER: pos=0, mismatch=0, go to IDLE; no error, fail_cnt unchanged.
  - clear and digit_valid in the same cycle: clear wins; the digit is not accepted.
  - clear in IDLE, CMP, PROG or WRITE is ignored.
- OPEN: unlocked=1; timer decrements each cycle.
  - prog_req=1: go to PROG, pos=0.
  - Else timer==0: go to IDLE.
  - prog_req has priority over timer expiry.
- PROG: unlocked=1. Digit accepted -> digit_q<=digit, go to WRITE.
- WRITE, one cycle: stores digit_q at idx pos; pos+1. At pos==3 go to IDLE (relock, unlocked=0); else go to PROG. No timeout in PROG.
- LOCKOUT: locked_out=1, digits dropped, timer counts down from LOCKOUT_CYCLES-1; at 0 go to IDLE with fail_cnt=0.
- Reset mid-operation (including during WRITE) returns to the reset state. A partially written code is lost because memory also resets to 0000.
- Timer width: $clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES)+1). fail_cnt width: $clog2(MAX_FAILS+1), saturating at MAX_FAILS.

Optional Feature:
- DIGILOCK_LOCKOUT_EN defined: when a wrong code makes fail_cnt reach MAX_FAILS, go to LOCKOUT instead of IDLE, with the error pulse in the same cycle.
- Undefined: no LOCKOUT state, fail_cnt logic removed, locked_out tied to 0, unlimited retries.

Decomposition:
- Package digilock_pkg: state enum, CODE_LEN=4, DIGIT_W=4, IDX_W=2.
- One sub-module, digilock_down_timer: loadable down-counter with a zero flag, shared by the OPEN and LOCKOUT states.

Test Plan:
- After reset, digits 0,0,0,0 -> 4 CMP reads at idx 0..3; unlocked=1 2 cycles after the 4th digit, held 8 cycles, then 0.
- Unlock with 0000, prog_req, digits 1,2,3,4 -> WRITE cycles with idx/wdata 0/1,1/2,2/3,3/4; unlocked drops after the last WRITE. Entering 1,2,3,4 -> unlocked=1.
- Code 1234 stored, digits 1,2,3,5 -> error one-cycle pulse, unlocked stays 0, next entry starts at idx 0.
- Digits 1,2, then clear together with digit_valid (digit 3) -> no error; entering 1,2,3,4 afterwards opens.
- DIGILOCK_LOCKOUT_EN: 3 wrong codes -> locked_out=1 for 16 cycles, digit_ready=0 throughout; a correct code afterwards opens.
- reset asserted during PROG after 2 WRITEs -> all outputs idle; code 0000 opens, 1200 does not.
